// File: rtl/mult_share_arbiter.sv
// -----------------------------------------------------------------------------
// mult_share_arbiter
//
// Two requesters share one shift-add multiplier. In IDLE a pending request is
// granted and its operands are captured. The engine then adds one partial
// product per clock for WIDTH clocks, and the product is returned with the ID
// of the requester that owns it.
//
// Parameters:
//   WIDTH    operand width (>= 2); the product is 2*WIDTH bits
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high; clears all state
//   req0/1   request from port 0/1; held high until the matching ack is seen
//   a0/1     multiplicand of port 0/1 (unsigned)
//   b0/1     multiplier of port 0/1 (unsigned)
//   ack0/1   one-cycle pulse: operands of port 0/1 were captured
//   busy     high while the engine is in RUN or DONE
//   done     one-cycle pulse: product/done_id are valid
//   done_id  requester that owns the current product
//   product  unsigned product; held until the next done
//
// Build option:
//   MULT_ARB_FAIR_RR_EN  defined   -> round-robin on contention
//                        undefined -> port 0 has fixed priority
// -----------------------------------------------------------------------------
module mult_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int PW    = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    product_q, product_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             owner_q, owner_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             done_q, done_d;
  logic             done_id_q, done_id_d;
  logic             grant1;
  logic [PW-1:0]    sum;

`ifdef MULT_ARB_FAIR_RR_EN
  logic             last_q, last_d;

  // On contention the port that did not win last time is served.
  assign grant1 = req1 & (~req0 | ~last_q);
`else
  assign grant1 = req1 & ~req0;
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    product_d = product_q;
    mplr_d    = mplr_q;
    cnt_d     = cnt_q;
    owner_d   = owner_q;
    ack0_d    = 1'b0;
    ack1_d    = 1'b0;
    done_d    = 1'b0;
    done_id_d = done_id_q;
`ifdef MULT_ARB_FAIR_RR_EN
    last_d    = last_q;
`endif
    sum       = acc_q + (mplr_q[0] ? mcand_q : '0);

    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          mcand_d = {{WIDTH{1'b0}}, (grant1 ? a1 : a0)};
          mplr_d  = grant1 ? b1 : b0;
          acc_d   = '0;
          cnt_d   = '0;
          owner_d = grant1;
          ack0_d  = ~grant1;
          ack1_d  = grant1;
`ifdef MULT_ARB_FAIR_RR_EN
          last_d  = grant1;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        // The last step's sum goes straight to the output register.
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          product_d = sum;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      mplr_q    <= '0;
      cnt_q     <= '0;
      owner_q   <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= 1'b0;
`ifdef MULT_ARB_FAIR_RR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      mplr_q    <= mplr_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      ack0_q    <= ack0_d;
      ack1_q    <= ack1_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
`ifdef MULT_ARB_FAIR_RR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign product = product_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
module tb_mult_share_arbiter;

  localparam int W  = 8;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1;
  logic [W-1:0]  a0, b0, a1, b1;
  logic          ack0, ack1, busy, done, done_id;
  logic [PW-1:0] product;

  always #5 clk = ~clk;

  mult_share_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
    .done_id(done_id), .product(product)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a job timer counting cycles since the capture edge,
  // with the result computed directly as a*b.
  int            m_phase;
  bit            m_owner, m_id, m_last;
  bit            e_ack0, e_ack1, e_done;
  logic [PW-1:0] m_prod;
  logic [W-1:0]  m_a, m_b;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_id = 0; m_last = 1;
    e_ack0 = 0; e_ack1 = 0; e_done = 0; m_prod = '0; m_a = '0; m_b = '0;
  endtask

  task automatic model_edge();
    bit win;
    if (reset) begin
      model_reset();
      return;
    end
    e_ack0 = 0; e_ack1 = 0; e_done = 0;
    if (m_phase == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) begin
`ifdef MULT_ARB_FAIR_RR_EN
          win = ~m_last;
`else
          win = 0;
`endif
        end else begin
          win = req1;
        end
        m_last  = win;
        m_owner = win;
        m_a     = win ? a1 : a0;
        m_b     = win ? b1 : b0;
        if (win) e_ack1 = 1; else e_ack0 = 1;
        m_phase = 1;
      end
    end else if (m_phase == W) begin
      m_prod  = PW'(m_a) * PW'(m_b);
      m_id    = m_owner;
      e_done  = 1;
      m_phase = W + 1;
    end else if (m_phase == W + 1) begin
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  // One clock: advance the model with the inputs seen at the edge, compare
  // all outputs just after the edge, and drop any acknowledged request.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    chk("ack0",    ack0,    e_ack0);
    chk("ack1",    ack1,    e_ack1);
    chk("done",    done,    e_done);
    chk("busy",    busy,    m_phase != 0);
    chk("done_id", done_id, m_id);
    chk("product", product, m_prod);
    if (ack0) req0 = 0;
    if (ack1) req1 = 0;
  endtask

  task automatic run_job(input bit port, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [PW-1:0] p, output bit id, output int lat,
                         output int busy_cnt);
    int  t_ack;
    bit  got;
    t_ack = -1; got = 0; lat = -1; busy_cnt = 0; p = '0; id = 0;
    if (port) begin req1 = 1; a1 = a; b1 = b; end
    else      begin req0 = 1; a0 = a; b0 = b; end
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if ((port && ack1) || (!port && ack0)) t_ack = i;
      if (t_ack >= 0 && busy) busy_cnt++;
      if (done) begin
        got = 1; p = product; id = done_id; lat = i - t_ack;
      end
    end
    if (!got) chk("job_timeout", 0, 1);
  endtask

  typedef struct {
    bit            port;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] p;
  } vec_t;

  vec_t          tbl[8];
  logic [PW-1:0] rp;
  bit            rid;
  int            lat, bcnt, c0, got, first_done;
  bit            exp_id;

  initial begin
    tbl[0] = '{0, 8'd255, 8'd255, 16'hFE01};
    tbl[1] = '{1, 8'd0,   8'd200, 16'd0};
    tbl[2] = '{0, 8'd1,   8'd1,   16'd1};
    tbl[3] = '{1, 8'd128, 8'd2,   16'd256};
    tbl[4] = '{0, 8'd255, 8'd0,   16'd0};
    tbl[5] = '{1, 8'd170, 8'd85,  16'd14450};
    tbl[6] = '{0, 8'd13,  8'd11,  16'd143};
    tbl[7] = '{1, 8'd255, 8'd1,   16'd255};

    reset = 1; req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    model_reset();
    tick(); tick();
    chk("rst_product", product, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", {ack0, ack1}, 0);
    reset = 0;
    tick();

    // 255*255 on port 0: done 8 cycles after the ack cycle.
    run_job(0, 8'd255, 8'd255, rp, rid, lat, bcnt);
    chk("t1_product", rp, 16'hFE01);
    chk("t1_id", rid, 0);
    chk("t1_latency", lat, 8);

    // Zero operand still runs all steps; busy from ack through done.
    run_job(1, 8'd0, 8'd200, rp, rid, lat, bcnt);
    chk("t2_product", rp, 0);
    chk("t2_id", rid, 1);
    chk("t2_latency", lat, 8);
    chk("t2_busy_cycles", bcnt, 9);

    for (int k = 0; k < 8; k++) begin
      run_job(tbl[k].port, tbl[k].a, tbl[k].b, rp, rid, lat, bcnt);
      chk($sformatf("tbl%0d_product", k), rp, tbl[k].p);
      chk($sformatf("tbl%0d_id", k), rid, tbl[k].port);
      chk($sformatf("tbl%0d_latency", k), lat, W);
    end

    // Continuous contention from both ports.
    a0 = 3; b0 = 5; a1 = 7; b1 = 9; req0 = 1; req1 = 1; got = 0;
    for (int i = 0; i < 200 && got < 4; i++) begin
      tick();
      if (done) begin
`ifdef MULT_ARB_FAIR_RR_EN
        exp_id = got[0];
`else
        exp_id = 0;
`endif
        chk($sformatf("t3_id%0d", got), done_id, exp_id);
        chk($sformatf("t3_product%0d", got), product, done_id ? 16'd63 : 16'd15);
        got++;
      end
      if (got < 4) begin
        if (!ack0) req0 = 1;
        if (!ack1) req1 = 1;
      end else begin
        req0 = 0; req1 = 0;
      end
    end
    chk("t3_done_count", got, 4);
    tick(); tick();

    // Port 1 requests while port 0's job is running.
    req0 = 1; a0 = 12; b0 = 10; c0 = -1;
    for (int i = 0; i < 5 && c0 < 0; i++) begin
      tick();
      if (ack0) c0 = cyc;
    end
    tick(); tick();
    req1 = 1; a1 = 5; b1 = 6; first_done = 0; got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (done && !first_done) begin
        chk("t4_first_product", product, 120);
        first_done = 1;
      end
      if (ack1) begin
        chk("t4_ack1_after_done", first_done, 1);
        chk("t4_ack1_edge", cyc - c0, W + 2);
        got = 1;
      end
    end
    chk("t4_ack1_seen", got, 1);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      if (done) begin
        chk("t4_second_product", product, 30);
        chk("t4_second_id", done_id, 1);
        got = 1;
      end else begin
        chk("t4_held", product, 120);
      end
    end
    chk("t4_second_done", got, 1);
    tick();

    // Reset in the middle of a 100*100 job.
    req0 = 1; a0 = 100; b0 = 100; got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      tick();
      if (ack0) got = 1;
    end
    tick(); tick(); tick();
    reset = 1;
    model_reset();
    #1;
    chk("t5_rst_product", product, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_ack", {ack0, ack1}, 0);
    tick();
    reset = 0;
    got = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) got = 1;
    end
    chk("t5_no_done", got, 0);
    run_job(0, 8'd2, 8'd3, rp, rid, lat, bcnt);
    chk("t5_product", rp, 6);
    chk("t5_id", rid, 0);

    // Random traffic checked against the model every cycle.
    for (int i = 0; i < 1500; i++) begin
      if (!req0 && !ack0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; a0 = W'($urandom); b0 = W'($urandom);
      end
      if (!req1 && !ack1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; a1 = W'($urandom); b1 = W'($urandom);
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one shift-add multiplier engine between two requesters (port 0, port 1) using a registered req/ack handshake.
- Arbitrates among pending requests and captures the winner's operands.
- Sequences the engine one partial product per clock.
- Returns the product tagged with the requester ID.
- Sits between the operand sources and the product/display logic; replaces per-requester multiplier instances.

Parameters:
WIDTH, 8, operand width in bits; product is 2*WIDTH bits; WIDTH >= 2.

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state
req0  input  1  port 0 request; held high until ack0 seen
a0  input  WIDTH  port 0 multiplicand (unsigned)
b0  input  WIDTH  port 0 multiplier (unsigned)
req1  input  1  port 1 request
a1  input  WIDTH  port 1 multiplicand
b1  input  WIDTH  port 1 multiplier
ack0  output  1  one-cycle pulse: port 0 operands captured
ack1  output  1  one-cycle pulse: port 1 operands captured
busy  output  1  high when state is RUN or DONE
done  output  1  one-cycle pulse: product/done_id valid
done_id  output  1  requester that owns the current product
product  output  2*WIDTH  unsigned product; held until next done

Behaviour:
Reset values:
- State = IDLE.
- ack0/ack1/busy/done/done_id = 0; product = 0.
- Internal accumulator, operand registers and count = 0.
- Internal last_grant = 1, so port 0 wins the first contention.

States and transitions:
- IDLE:
  - No req: stay.
  - Any req at a rising edge:
    - Grant one requester.
    - Capture its a into the multiplicand register (zero-extended to 2*WIDTH) and its b into the multiplier register.
    - Clear accumulator; count = 0.
    - Set the granted ack = 1 for exactly the next cycle; update last_grant.
    - Go to RUN.
- RUN, each edge:
  - If multiplier LSB = 1, accumulator += multiplicand.
  - Multiplicand <<= 1; multiplier >>= 1; count++.
  - On the edge where count == WIDTH-1: perform the step, copy the final sum to product, set done = 1, done_id = granted port, go to DONE.
- DONE: done high for this one cycle; next edge: done = 0, go to IDLE.

Arbitration:
- Requests are sampled only in IDLE.
- A req arriving during RUN/DONE waits; it is not lost as long as the requester holds it.

Timing:
- Latency: capture edge T0; RUN step edges T1..T_WIDTH; done high in the cycle after edge T_WIDTH.
- Earliest next capture is edge T_WIDTH+2.
- Throughput: one multiply per WIDTH+2 cycles.

Handshake:
- The requester must deassert req in the cycle ack is high.
- req still high at the next IDLE edge is treated as a new request.
- Operands need only be stable at the capture edge.

Arithmetic and hold rules:
- Unsigned; no overflow possible in 2*WIDTH bits.
- Zero operands still take the full WIDTH steps.
- product and done_id hold their last value through IDLE and the next RUN; they change only on the done-setting edge.

Reset mid-operation:
- Immediate return to reset values.
- No done pulse; in-flight request dropped; the requester must re-request.

Optional Feature:
Macro: MULT_ARB_FAIR_RR_EN.
- Defined: round-robin arbitration.
  - When both req0 and req1 are high in IDLE, the port not in last_grant wins.
  - A single requester always wins regardless of last_grant.
- Undefined: fixed priority; port 0 always wins contention; last_grant is unused (may be removed).
- All other behaviour is identical in both builds.

Test Plan:
1. Reset, req0 with a0=255, b0=255, WIDTH=8:
   - ack0 pulses 1 cycle after the capture edge.
   - done pulses exactly 8 cycles later with product=16'hFE01, done_id=0.
2. req1 with a1=0, b1=200:
   - product=0, done_id=1 after the full 8-step latency.
   - busy high from the ack cycle through the done cycle.
3. req0 and req1 raised together repeatedly (a0=3,b0=5; a1=7,b1=9):
   - With MULT_ARB_FAIR_RR_EN: grants alternate 0,1,0,1; products 15 and 63 tagged with the correct done_id.
   - Without the macro: port 0 wins every contention.
4. req1 raised during RUN of a port-0 job:
   - No ack1 until after done.
   - ack1 at edge T_WIDTH+2; the first product (12*10=120) stays held until the second done.
5. Assert reset for 1 cycle at RUN step 4 of a 100*100 job:
   - No done pulse; product=0, busy=0, ack0/ack1=0.
   - A new req0 (a0=2, b0=3) afterwards yields product=6.
